// File: rtl/pixel_recover_param.sv
// pixel_recover_param
// Turns a camera pixel strobe (possibly stretched over several cycles) into
// single-cycle pixel beats tagged with in-frame column/row coordinates, and
// adds frame/line markers plus short-frame and overflow error reporting.
// Everything runs on system_clk_in with a synchronous active-high reset.
//
// Ports:
//   system_clk_in        system clock
//   rst_in               synchronous active-high reset
//   valid_pixel_in       pixel strobe (level, may stay high several cycles)
//   pixel_in             pixel data, sampled on the qualifying cycle
//   frame_done_in        end-of-frame pulse from the capture path
//   pixel_out            captured pixel, held between beats
//   data_valid_out       1-cycle beat strobe for pixel_out/hcount_out/vcount_out
//   hcount_out           column of pixel_out
//   vcount_out           row of pixel_out
//   frame_start_out      high with beat (0,0)
//   line_end_out         high with the last beat of a line
//   frame_end_out        high with the last beat of a frame
//   short_frame_err_out  1-cycle pulse when a frame ends before it is full
//   overflow_err_out     sticky: pixel arrived after a full frame
//   frame_count_out      number of completed full frames (wraps)
module pixel_recover_param #(
  parameter int PIXEL_W   = 16,
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int HCOUNT_W  = 11,
  parameter int VCOUNT_W  = 10,
  parameter int EDGE_MODE = 1,
  parameter int FCOUNT_W  = 8
) (
  input  logic                system_clk_in,
  input  logic                rst_in,
  input  logic                valid_pixel_in,
  input  logic [PIXEL_W-1:0]  pixel_in,
  input  logic                frame_done_in,
  output logic [PIXEL_W-1:0]  pixel_out,
  output logic                data_valid_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                frame_start_out,
  output logic                line_end_out,
  output logic                frame_end_out,
  output logic                short_frame_err_out,
  output logic                overflow_err_out,
  output logic [FCOUNT_W-1:0] frame_count_out
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_ACTIVE - 1);

  state_t              state;
  logic                prev_valid;
  logic [HCOUNT_W-1:0] col;
  logic [VCOUNT_W-1:0] row;
  logic                q;

  // In edge mode a strobe held high for several cycles counts only once;
  // prev_valid keeps tracking across frame_done so a held strobe never
  // produces a fresh beat after the frame boundary.
  assign q = (EDGE_MODE != 0) ? (valid_pixel_in & ~prev_valid) : valid_pixel_in;

  // col/row are always 0 while IDLE, so the IDLE beat is simply the first
  // ACTIVE beat with frame_start_out raised. That also covers H_ACTIVE=1 and
  // V_ACTIVE=1, where the very first beat already ends the line or frame.
  always_ff @(posedge system_clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      prev_valid          <= 1'b0;
      col                 <= '0;
      row                 <= '0;
      pixel_out           <= '0;
      data_valid_out      <= 1'b0;
      hcount_out          <= '0;
      vcount_out          <= '0;
      frame_start_out     <= 1'b0;
      line_end_out        <= 1'b0;
      frame_end_out       <= 1'b0;
      short_frame_err_out <= 1'b0;
      overflow_err_out    <= 1'b0;
      frame_count_out     <= '0;
    end else begin
      prev_valid          <= valid_pixel_in;
      data_valid_out      <= 1'b0;
      frame_start_out     <= 1'b0;
      line_end_out        <= 1'b0;
      frame_end_out       <= 1'b0;
      short_frame_err_out <= 1'b0;

      // frame_done wins over a coincident pixel, which is dropped.
      if (frame_done_in) begin
        col                 <= '0;
        row                 <= '0;
        state               <= IDLE;
        short_frame_err_out <= (state == ACTIVE);
      end else if (q && state != FULL) begin
        data_valid_out  <= 1'b1;
        pixel_out       <= pixel_in;
        hcount_out      <= col;
        vcount_out      <= row;
        frame_start_out <= (state == IDLE);
        state           <= ACTIVE;
        if (col == H_LAST) begin
          line_end_out <= 1'b1;
          col          <= '0;
          if (row == V_LAST) begin
            frame_end_out   <= 1'b1;
            frame_count_out <= frame_count_out + 1'b1;
            row             <= '0;
            state           <= FULL;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end else if (q) begin
        // A full frame has already been delivered; the extra pixel is dropped.
        overflow_err_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_recover_param.sv
// tb_pixel_recover_param
// Self-checking bench for pixel_recover_param. Two small instances share one
// clock: an edge-mode 4x3 frame and a level-mode 1x2 frame (single-pixel
// lines). Directed vectors come from a table; full-frame, overflow, counter
// wrap and short-frame sequences are written out as loops.
module tb_pixel_recover_param;

  typedef struct packed {
    logic       dv;
    logic [7:0] pix;
    logic [7:0] h;
    logic [7:0] v;
    logic       fs;
    logic       le;
    logic       fe;
    logic       se;
    logic       ov;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    string      name;
    bit         sel;
    logic       rst;
    logic       valid;
    logic       done;
    logic [7:0] pix;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Edge-mode instance signals
  logic       e_rst = 1'b0, e_valid = 1'b0, e_done = 1'b0;
  logic [7:0] e_pix_in = '0;
  logic [7:0] e_pix;
  logic       e_dv, e_fs, e_le, e_fe, e_se, e_ov;
  logic [1:0] e_h;
  logic [1:0] e_v;
  logic [1:0] e_fc;

  // Level-mode instance signals
  logic       l_rst = 1'b0, l_valid = 1'b0, l_done = 1'b0;
  logic [7:0] l_pix_in = '0;
  logic [7:0] l_pix;
  logic       l_dv, l_fs, l_le, l_fe, l_se, l_ov;
  logic [0:0] l_h;
  logic [0:0] l_v;
  logic [1:0] l_fc;

  always #5 clk = ~clk;

  pixel_recover_param #(
    .PIXEL_W(8), .H_ACTIVE(4), .V_ACTIVE(3), .HCOUNT_W(2), .VCOUNT_W(2),
    .EDGE_MODE(1), .FCOUNT_W(2)
  ) dut_e (
    .system_clk_in(clk), .rst_in(e_rst), .valid_pixel_in(e_valid),
    .pixel_in(e_pix_in), .frame_done_in(e_done), .pixel_out(e_pix),
    .data_valid_out(e_dv), .hcount_out(e_h), .vcount_out(e_v),
    .frame_start_out(e_fs), .line_end_out(e_le), .frame_end_out(e_fe),
    .short_frame_err_out(e_se), .overflow_err_out(e_ov), .frame_count_out(e_fc)
  );

  pixel_recover_param #(
    .PIXEL_W(8), .H_ACTIVE(1), .V_ACTIVE(2), .HCOUNT_W(1), .VCOUNT_W(1),
    .EDGE_MODE(0), .FCOUNT_W(2)
  ) dut_l (
    .system_clk_in(clk), .rst_in(l_rst), .valid_pixel_in(l_valid),
    .pixel_in(l_pix_in), .frame_done_in(l_done), .pixel_out(l_pix),
    .data_valid_out(l_dv), .hcount_out(l_h), .vcount_out(l_v),
    .frame_start_out(l_fs), .line_end_out(l_le), .frame_end_out(l_fe),
    .short_frame_err_out(l_se), .overflow_err_out(l_ov), .frame_count_out(l_fc)
  );

  function automatic out_t mk(input logic dv, input logic [7:0] pix,
                              input logic [7:0] h, input logic [7:0] v,
                              input logic fs, input logic le, input logic fe,
                              input logic se, input logic ov, input logic [7:0] fc);
    out_t o;
    o.dv = dv; o.pix = pix; o.h = h; o.v = v;
    o.fs = fs; o.le = le; o.fe = fe; o.se = se; o.ov = ov; o.fc = fc;
    return o;
  endfunction

  function automatic out_t snap(input bit sel);
    if (sel)
      return mk(l_dv, l_pix, 8'(l_h), 8'(l_v), l_fs, l_le, l_fe, l_se, l_ov, 8'(l_fc));
    else
      return mk(e_dv, e_pix, 8'(e_h), 8'(e_v), e_fs, e_le, e_fe, e_se, e_ov, 8'(e_fc));
  endfunction

  // Drive one cycle of inputs on the selected instance, then sample 1 ns
  // after the rising edge that consumed them.
  task automatic applyStimulus(input bit sel, input logic rst, input logic valid,
                               input logic done, input logic [7:0] pix);
    if (sel) begin
      l_rst = rst; l_valid = valid; l_done = done; l_pix_in = pix;
    end else begin
      e_rst = rst; e_valid = valid; e_done = done; e_pix_in = pix;
    end
    @(posedge clk);
    #1;
  endtask

  // Coordinates are only meaningful on a beat, so they are masked otherwise.
  task automatic checkOutput(input string name, input bit sel, input out_t exp);
    out_t act;
    act = snap(sel);
    if (!exp.dv) begin
      act.h = '0; act.v = '0; exp.h = '0; exp.v = '0;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got dv=%b pix=%h h=%0d v=%0d fs=%b le=%b fe=%b se=%b ov=%b fc=%0d, expected dv=%b pix=%h h=%0d v=%0d fs=%b le=%b fe=%b se=%b ov=%b fc=%0d",
               name, act.dv, act.pix, act.h, act.v, act.fs, act.le, act.fe, act.se, act.ov, act.fc,
               exp.dv, exp.pix, exp.h, exp.v, exp.fs, exp.le, exp.fe, exp.se, exp.ov, exp.fc);
    end
  endtask

  initial begin
    vec_t       vecs[$];
    logic [1:0] fc;
    logic       ov;
    logic [7:0] p;

    // name, sel, rst, valid, done, pix, expected{dv,pix,h,v,fs,le,fe,se,ov,fc}
    vecs.push_back('{"e_reset",        0, 1, 0, 0, 8'h00, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_first_beat",   0, 0, 1, 0, 8'hA1, mk(1, 8'hA1, 0, 0, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_held_valid",   0, 0, 1, 0, 8'hB2, mk(0, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_valid_low",    0, 0, 0, 0, 8'h00, mk(0, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_second_beat",  0, 0, 1, 0, 8'hC3, mk(1, 8'hC3, 1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_low2",         0, 0, 0, 0, 8'h00, mk(0, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_short_err",    0, 0, 0, 1, 8'h00, mk(0, 8'hC3, 0, 0, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{"e_short_clear",  0, 0, 0, 0, 8'h00, mk(0, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_edge_on_done", 0, 0, 1, 1, 8'hD4, mk(0, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_held_after",   0, 0, 1, 0, 8'hE5, mk(0, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_low3",         0, 0, 0, 0, 8'h00, mk(0, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_restart_beat", 0, 0, 1, 0, 8'hF6, mk(1, 8'hF6, 0, 0, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_low4",         0, 0, 0, 0, 8'h00, mk(0, 8'hF6, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_midline_rst",  0, 1, 0, 0, 8'h00, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_post_rst",     0, 0, 1, 0, 8'h77, mk(1, 8'h77, 0, 0, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"e_low5",         0, 0, 0, 0, 8'h00, mk(0, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"l_reset",        1, 1, 0, 0, 8'h00, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"l_beat0",        1, 0, 1, 0, 8'h10, mk(1, 8'h10, 0, 0, 1, 1, 0, 0, 0, 0)});
    vecs.push_back('{"l_beat1_end",    1, 0, 1, 0, 8'h11, mk(1, 8'h11, 0, 1, 0, 1, 1, 0, 0, 1)});
    vecs.push_back('{"l_overflow",     1, 0, 1, 0, 8'h12, mk(0, 8'h11, 0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"l_done_full",    1, 0, 1, 1, 8'h13, mk(0, 8'h11, 0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"l_level_beat",   1, 0, 1, 0, 8'h14, mk(1, 8'h14, 0, 0, 1, 1, 0, 0, 1, 1)});
    vecs.push_back('{"l_low",          1, 0, 0, 0, 8'h00, mk(0, 8'h14, 0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"l_short_err",    1, 0, 0, 1, 8'h00, mk(0, 8'h14, 0, 0, 0, 0, 0, 1, 1, 1)});
    vecs.push_back('{"l_restart",      1, 0, 1, 0, 8'h15, mk(1, 8'h15, 0, 0, 1, 1, 0, 0, 1, 1)});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].rst, vecs[i].valid, vecs[i].done, vecs[i].pix);
      checkOutput(vecs[i].name, vecs[i].sel, vecs[i].exp);
    end

    // Five full frames on the edge-mode instance: overflow after the first,
    // frame counter wrapping through 2 bits.
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("frm_reset", 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    fc = 2'd0;
    ov = 1'b0;
    p  = 8'h00;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 12; k++) begin
        p = 8'(f * 16 + k + 1);
        if (k == 11) fc = fc + 2'd1;
        applyStimulus(0, 0, 1, 0, p);
        checkOutput($sformatf("f%0d_beat%0d", f, k), 0,
                    mk(1, p, 8'(k % 4), 8'(k / 4), (k == 0), (k % 4 == 3), (k == 11), 0, ov, 8'(fc)));
        applyStimulus(0, 0, 0, 0, 8'h00);
        checkOutput($sformatf("f%0d_gap%0d", f, k), 0, mk(0, p, 0, 0, 0, 0, 0, 0, ov, 8'(fc)));
      end
      if (f == 0) begin
        for (int x = 0; x < 3; x++) begin
          ov = 1'b1;
          applyStimulus(0, 0, 1, 0, 8'(8'hE0 + x));
          checkOutput($sformatf("extra%0d", x), 0, mk(0, p, 0, 0, 0, 0, 0, 0, 1, 8'(fc)));
          applyStimulus(0, 0, 0, 0, 8'h00);
          checkOutput($sformatf("extra%0d_gap", x), 0, mk(0, p, 0, 0, 0, 0, 0, 0, 1, 8'(fc)));
        end
      end
      applyStimulus(0, 0, 0, 1, 8'h00);
      checkOutput($sformatf("f%0d_done", f), 0, mk(0, p, 0, 0, 0, 0, 0, 0, ov, 8'(fc)));
    end

    // Short frame: five pixels, then frame_done in the middle of row 1.
    for (int k = 0; k < 5; k++) begin
      p = 8'(8'h90 + k);
      applyStimulus(0, 0, 1, 0, p);
      checkOutput($sformatf("short_beat%0d", k), 0,
                  mk(1, p, 8'(k % 4), 8'(k / 4), (k == 0), (k % 4 == 3), 0, 0, 1, 8'(fc)));
      applyStimulus(0, 0, 0, 0, 8'h00);
    end
    applyStimulus(0, 0, 0, 1, 8'h00);
    checkOutput("short_pulse", 0, mk(0, p, 0, 0, 0, 0, 0, 1, 1, 8'(fc)));
    applyStimulus(0, 0, 0, 1, 8'h00);
    checkOutput("short_repeat_done", 0, mk(0, p, 0, 0, 0, 0, 0, 0, 1, 8'(fc)));
    applyStimulus(0, 0, 1, 0, 8'h5A);
    checkOutput("short_next_frame", 0, mk(1, 8'h5A, 0, 0, 1, 0, 0, 0, 1, 8'(fc)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
